// File: rtl/piano_pkg.sv
// Shared constants and types for the piano tone scheduler: note table, FSM states, width helper.
package piano_pkg;

    localparam int unsigned CLK_HZ  = 100_000_000;
    localparam int unsigned N_TABLE = 8;

    // Half-period in clk cycles for C4, D4, E4, F4, G4, A4, B4, C5 at CLK_HZ
    localparam int unsigned HALF_PERIOD [0:N_TABLE-1] = '{
        191110, 170265, 151685, 143172, 127551, 113636, 101239, 95557
    };

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser bringing the asynchronous key levels into the clk_in domain.
module key_sync #(
    parameter int unsigned W = 8
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/piano_tone_scheduler.sv
// Shares one tone divider among N_KEYS keys (lowest index wins), retuning only at half-period edges.
// Optional macro PIANO_OCTAVE_SHIFT_EN adds an octave_up input that halves the selected half-period.
module piano_tone_scheduler
    import piano_pkg::*;
#(
    parameter int unsigned N_KEYS        = 8,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned SIM_DIV_SHIFT = 0
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic [N_KEYS-1:0]         key,
    output logic                      tone_out,
    output logic                      active,
    output logic [idx_w(N_KEYS)-1:0]  note_idx
`ifdef PIANO_OCTAVE_SHIFT_EN
    ,
    input  logic                      octave_up
`endif
);

    localparam int unsigned IDX_W = idx_w(N_KEYS);

    if (N_KEYS < 1 || N_KEYS > N_TABLE) begin : g_bad_n_keys
        $error("piano_tone_scheduler: N_KEYS must be 1..8");
    end
    if (64'(HALF_PERIOD[0] >> SIM_DIV_SHIFT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cnt_w
        $error("piano_tone_scheduler: CNT_W too small for the note table");
    end

    logic [N_KEYS-1:0] key_s;
    logic [IDX_W-1:0]  grant;
    logic [CNT_W-1:0]  half;
    int unsigned       entry;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic [IDX_W-1:0]  note_q, note_d;
    logic              tone_q, tone_d;
    logic              active_q, active_d;

    key_sync #(.W(N_KEYS)) u_key_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (key),
        .q      (key_s)
    );

    // Fixed priority: lowest set index wins
    always_comb begin
        grant = '0;
        for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
            if (key_s[i]) grant = IDX_W'(i);
        end
    end

    // Half-period of the granted note, floored at 2 so the terminal count is never 0
    always_comb begin
        entry = HALF_PERIOD[grant] >> SIM_DIV_SHIFT;
`ifdef PIANO_OCTAVE_SHIFT_EN
        entry = entry >> octave_up;
`endif
        half = (entry < 2) ? CNT_W'(2) : CNT_W'(entry);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            half_q    <= '0;
            note_q    <= '0;
            tone_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            half_q    <= half_d;
            note_q    <= note_d;
            tone_q    <= tone_d;
            active_q  <= active_d;
        end
    end

    // Note selection is latched only at phase boundaries so every phase has its owner's full length
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        half_d    = half_q;
        note_d    = note_q;
        tone_d    = tone_q;
        active_d  = active_q;
        unique case (state_q)
            IDLE: begin
                tone_d    = 1'b0;
                active_d  = 1'b0;
                counter_d = '0;
                if (key_s != '0) begin
                    half_d   = half;
                    note_d   = grant;
                    tone_d   = 1'b1;
                    active_d = 1'b1;
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == half_q - CNT_W'(1)) begin
                    counter_d = '0;
                    if (key_s != '0) begin
                        tone_d = ~tone_q;
                        half_d = half;
                        note_d = grant;
                    end else begin
                        tone_d   = 1'b0;
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tone_out = tone_q;
    assign active   = active_q;
    assign note_idx = note_q;

endmodule

// File: tb/tb_piano_tone_scheduler.sv
// Scoreboard bench: expected tone phases are queued with the stimulus and compared as each phase ends.
module tb_piano_tone_scheduler;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic [7:0] key;
    logic       tone_out;
    logic       active;
    logic [2:0] note_idx;
`ifdef PIANO_OCTAVE_SHIFT_EN
    logic       octave_up;
`endif

    typedef struct packed {
        logic        tone;
        logic [2:0]  note;
        logic [19:0] len;
    } phase_t;

    phase_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    logic       p_tone = 1'b0;
    logic       p_act  = 1'b0;
    logic [2:0] p_note = 3'd0;
    int         run    = 0;

    always #5 clk_in = ~clk_in;

    piano_tone_scheduler #(
        .N_KEYS        (8),
        .CNT_W         (20),
        .SIM_DIV_SHIFT (10)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .key      (key),
        .tone_out (tone_out),
        .active   (active),
        .note_idx (note_idx)
`ifdef PIANO_OCTAVE_SHIFT_EN
        ,
        .octave_up(octave_up)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Each completed playing phase (tone level, note, length in cycles) is checked against the queue
    always @(negedge clk_in) begin
        if (tone_out !== p_tone || active !== p_act || note_idx !== p_note) begin
            if (p_act === 1'b1) begin
                if (exp_q.size() == 0)
                    check("phase_extra", {8'h00, p_tone, p_note, 20'(run)}, 32'hFFFF_FFFF);
                else
                    check("phase", {8'h00, p_tone, p_note, 20'(run)}, 32'(exp_q.pop_front()));
            end
            run <= 1;
        end else begin
            run <= run + 1;
        end
        p_tone <= tone_out;
        p_act  <= active;
        p_note <= note_idx;
    end

    task automatic push(input logic t, input logic [2:0] n, input int l);
        exp_q.push_back({t, n, 20'(l)});
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk_in); #2;
            k++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic idle_check(input string tag, input int ncyc);
        repeat (ncyc) begin
            @(posedge clk_in); #2;
            check(tag, {30'd0, tone_out, active}, 32'd0);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 8'h00;
`ifdef PIANO_OCTAVE_SHIFT_EN
        octave_up = 1'b0;
`endif
        cyc(3);
        check("rst_tone",   32'(tone_out), 32'd0);
        check("rst_active", 32'(active),   32'd0);
        check("rst_note",   32'(note_idx), 32'd0);
        rst_n = 1'b1;

        // 1: idle with no keys
        repeat (500) begin
            cyc(1);
            check("t1_idle", {28'd0, tone_out, active, note_idx}, 32'd0);
        end

        // 2: single key, press latency then 186-cycle phases
        push(1'b1, 3'd0, 186); push(1'b0, 3'd0, 186);
        push(1'b1, 3'd0, 186); push(1'b0, 3'd0, 186);
        key = 8'h01;
        cyc(1); check("t2_edge0", {30'd0, tone_out, active}, 32'd0);
        cyc(1); check("t2_edge1", {30'd0, tone_out, active}, 32'd0);
        cyc(1); check("t2_edge2", {28'd0, tone_out, active, note_idx}, {28'd0, 1'b1, 1'b1, 3'd0});
        drain();

        // 4: release 50 cycles into a high phase; high still lasts the full 186
        push(1'b1, 3'd0, 186);
        cyc(49);
        key = 8'h00;
        drain();
        idle_check("t4_idle", 20);

        // 3: simultaneous press, lower index wins; drop it mid-phase
        key = 8'h21;
        push(1'b1, 3'd0, 186); push(1'b0, 3'd0, 186);
        drain();
        push(1'b1, 3'd0, 186);
        push(1'b0, 3'd5, 110); push(1'b1, 3'd5, 110); push(1'b0, 3'd5, 110);
        cyc(60);
        key = 8'h20;
        drain();
        push(1'b1, 3'd5, 110);
        key = 8'h00;
        drain();
        idle_check("t3_idle", 10);

        // 5: one-edge reset mid-phase while A4 plays
        key = 8'h20;
        push(1'b1, 3'd5, 110); push(1'b0, 3'd5, 110);
        drain();
        cyc(40);
        push(1'b1, 3'd5, 42);
        rst_n = 1'b0;
        cyc(1);
        check("t5_rst", {28'd0, tone_out, active, note_idx}, 32'd0);
        rst_n = 1'b1;
        push(1'b1, 3'd5, 110);
        cyc(1); check("t5_refill0", {30'd0, tone_out, active}, 32'd0);
        cyc(1); check("t5_refill1", {30'd0, tone_out, active}, 32'd0);
        cyc(1); check("t5_restart", {28'd0, tone_out, active, note_idx}, {28'd0, 1'b1, 1'b1, 3'd5});
        drain();
        push(1'b0, 3'd5, 110);
        key = 8'h00;
        drain();
        idle_check("t5_idle", 10);

`ifdef PIANO_OCTAVE_SHIFT_EN
        // 6: octave shift sampled only at boundaries
        octave_up = 1'b1;
        key = 8'h80;
        push(1'b1, 3'd7, 46); push(1'b0, 3'd7, 46);
        drain();
        push(1'b1, 3'd7, 46);
        push(1'b0, 3'd7, 93); push(1'b1, 3'd7, 93);
        cyc(10);
        octave_up = 1'b0;
        drain();
        push(1'b0, 3'd7, 93);
        key = 8'h00;
        drain();
        idle_check("t6_idle", 10);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
